// File: rtl/complex_pkg.sv
// Shared types and constants for the complex dot-product feeder.
//   cplx_t      : one complex double, {im, re}
//   LANE_WORDS  : 64-bit words per engine lane
//   XRE..YIM    : word offsets of each operand component inside a lane
//   RES_WIDTH   : result FIFO entry width, {last, cplx_t}
package complex_pkg;

  typedef struct packed {
    logic [63:0] im;
    logic [63:0] re;
  } cplx_t;

  localparam int unsigned LANE_WORDS = 4;
  localparam int unsigned XRE = 0;
  localparam int unsigned XIM = 1;
  localparam int unsigned YRE = 2;
  localparam int unsigned YIM = 3;

  localparam int unsigned RES_WIDTH = 1 + $bits(cplx_t);

  typedef enum logic [0:0] {
    StFill,
    StIssue
  } feeder_state_e;

endpackage

// File: rtl/cplx_res_fifo.sv
// First-word-fall-through FIFO with synchronous flush.
//   clk_i, rst_ni    : clock, async active-low reset
//   flush_i          : empties the FIFO; wins over push/pop in the same cycle
//   push_i, data_i   : write port, ignored while full
//   pop_i, data_o    : read port, data_o shows the head whenever empty_o is 0
//   full_o, empty_o  : occupancy flags
module cplx_res_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    if (pop_ok)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/complex_dot_feeder.sv
// Initiator side of the complex dot-product engine.
// Packs up to SIZE complex operand pairs into one wide beat, issues it to the engine under a
// credit limit, and returns each engine sum in issue order together with the beat's last tag.
//   elem_*   : operand pair stream in (x, y as {im,re} doubles, last marks end of vector)
//   eng_*    : wide operand beat out, engine sum back, flush passthrough
//   res_*    : {im,re} sum out with last tag (0 = partial chunk)
//   busy_o   : work pending anywhere in the block
//   err_o    : sticky, engine returned a result with no beat outstanding
module complex_dot_feeder
  import complex_pkg::*;
#(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               elem_valid_i,
  output logic                               elem_ready_o,
  input  logic [1:0][63:0]                   elem_x_i,
  input  logic [1:0][63:0]                   elem_y_i,
  input  logic                               elem_last_i,
  output logic [SIZE*LANE_WORDS-1:0][63:0]   eng_operands_o,
  output logic                               eng_valid_o,
  input  logic                               eng_ready_i,
  output logic                               eng_flush_o,
  input  logic [1:0][63:0]                   eng_result_i,
  input  logic                               eng_valid_i,
  output logic                               eng_ready_o,
  output logic [1:0][63:0]                   res_data_o,
  output logic                               res_last_o,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output logic                               busy_o,
  output logic                               err_o
);

  localparam int unsigned IdxW     = $clog2(SIZE);
  localparam int unsigned CntW     = IdxW + 1;
  localparam int unsigned LaneSelW = $clog2(LANE_WORDS);
  localparam int unsigned WordIdxW = IdxW + LaneSelW;
  localparam int unsigned CreditW  = $clog2(RES_DEPTH + 1);
  localparam logic [CntW-1:0]    FullCnt   = CntW'(SIZE);
  localparam logic [CreditW-1:0] MaxCredit = CreditW'(RES_DEPTH);

  feeder_state_e                       state_q, state_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [SIZE*LANE_WORDS-1:0][63:0]    lanes_q, lanes_d;
  logic                                tag_q, tag_d;
  logic [CreditW-1:0]                  credit_q, credit_d;
  logic                                err_q, err_d;

  logic                elem_hs, issue_hs, eng_hs, res_pop;
  logic [WordIdxW-1:0] lane_base;
  logic                tag_full, tag_empty, tag_head;
  logic                res_full, res_empty;
  logic [RES_WIDTH-1:0] res_word;
  cplx_t               res_sum;

  assign elem_ready_o = (state_q == StFill);
  // Credit covers both FIFOs: a beat is only issued if its result is sure to find a slot.
  assign eng_valid_o  = (state_q == StIssue) && (credit_q < MaxCredit);
  assign elem_hs      = elem_valid_i & elem_ready_o;
  assign issue_hs     = eng_valid_o & eng_ready_i;
  assign eng_ready_o  = ~res_full;
  assign eng_hs       = eng_valid_i & eng_ready_o;
  assign res_valid_o  = ~res_empty;
  assign res_pop      = res_valid_o & res_ready_i;

  // First word of the current lane: lane_cnt * LANE_WORDS.
  assign lane_base = {cnt_q[IdxW-1:0], LaneSelW'(0)};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lanes_d  = lanes_q;
    tag_d    = tag_q;
    credit_d = credit_q;
    err_d    = err_q;

    unique case (state_q)
      StFill: begin
        if (elem_hs) begin
          lanes_d[lane_base + WordIdxW'(XRE)] = elem_x_i[0];
          lanes_d[lane_base + WordIdxW'(XIM)] = elem_x_i[1];
          lanes_d[lane_base + WordIdxW'(YRE)] = elem_y_i[0];
          lanes_d[lane_base + WordIdxW'(YIM)] = elem_y_i[1];
          cnt_d = cnt_q + 1'b1;
          if (elem_last_i || (cnt_d == FullCnt)) begin
            state_d = StIssue;
            tag_d   = elem_last_i;
          end
        end
      end
      StIssue: begin
        if (issue_hs) begin
          // Clearing here is what zero-pads the unused lanes of the next beat.
          lanes_d = '0;
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    unique case ({issue_hs, res_pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase

    if (eng_hs && tag_empty) err_d = 1'b1;

    if (flush_i) begin
      state_d  = StFill;
      cnt_d    = '0;
      lanes_d  = '0;
      tag_d    = 1'b0;
      credit_d = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StFill;
      cnt_q    <= '0;
      lanes_q  <= '0;
      tag_q    <= 1'b0;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lanes_q  <= lanes_d;
      tag_q    <= tag_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  cplx_res_fifo #(
    .Width (1),
    .Depth (RES_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (issue_hs & ~tag_full),
    .data_i  (tag_q),
    .pop_i   (eng_hs),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  // A result with no matching tag is dropped rather than stored untagged.
  cplx_res_fifo #(
    .Width (RES_WIDTH),
    .Depth (RES_DEPTH)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (eng_hs & ~tag_empty),
    .data_i  ({tag_head, eng_result_i}),
    .pop_i   (res_pop),
    .data_o  (res_word),
    .full_o  (res_full),
    .empty_o (res_empty)
  );

  assign res_sum        = res_word[RES_WIDTH-2:0];
  assign res_data_o     = {res_sum.im, res_sum.re};
  assign res_last_o     = res_word[RES_WIDTH-1];
  assign eng_operands_o = lanes_q;
  assign eng_flush_o    = flush_i;
  assign busy_o         = (cnt_q != '0) | (state_q == StIssue) | (credit_q != '0);
  assign err_o          = err_q;

endmodule

// File: tb/tb_complex_dot_feeder.sv
module tb_complex_dot_feeder;

  localparam int SIZE      = 16;
  localparam int RES_DEPTH = 4;
  localparam int NW        = SIZE * 4;

  typedef logic [NW-1:0][63:0] beat_t;
  typedef struct packed {
    logic [63:0] xr, xi, yr, yi;
    logic        last;
  } pair_t;

  logic clk = 1'b0;
  logic rst_ni, flush_i;
  logic elem_valid_i, elem_ready_o, elem_last_i;
  logic [1:0][63:0] elem_x_i, elem_y_i;
  beat_t eng_operands_o;
  logic eng_valid_o, eng_ready_i, eng_flush_o, eng_valid_i, eng_ready_o;
  logic [1:0][63:0] eng_result_i, res_data_o;
  logic res_last_o, res_valid_o, res_ready_i, busy_o, err_o;

  always #5 clk = ~clk;

  complex_dot_feeder #(
    .SIZE      (SIZE),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .elem_valid_i   (elem_valid_i),
    .elem_ready_o   (elem_ready_o),
    .elem_x_i       (elem_x_i),
    .elem_y_i       (elem_y_i),
    .elem_last_i    (elem_last_i),
    .eng_operands_o (eng_operands_o),
    .eng_valid_o    (eng_valid_o),
    .eng_ready_i    (eng_ready_i),
    .eng_flush_o    (eng_flush_o),
    .eng_result_i   (eng_result_i),
    .eng_valid_i    (eng_valid_i),
    .eng_ready_o    (eng_ready_o),
    .res_data_o     (res_data_o),
    .res_last_o     (res_last_o),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model queues: filled when a vector is generated, drained by the agents.
  pair_t        src_q[$];
  beat_t        exp_beat_q[$];
  logic [128:0] exp_res_q[$];   // {last, im, re}
  logic [127:0] eng_q[$];       // engine sums awaiting return, {im, re}

  bit src_en, eng_rdy_en, resp_en, sink_en, throttle;
  int issued = 0;

  // A vector splits into chunks of SIZE pairs; each chunk is one beat and one result.
  // Only the final chunk of a vector carries last=1. A tail without last never issues.
  task automatic add_vector(input int n, input bit with_last, input bit fixed);
    beat_t b;
    real sr, si, xr, xi, yr, yi;
    int k;
    pair_t p;
    b = '0; sr = 0.0; si = 0.0; k = 0;
    for (int i = 0; i < n; i++) begin
      if (fixed) begin
        xr = 1.0; xi = 0.0; yr = 2.0; yi = 0.0;
      end else begin
        xr = real'(int'($urandom_range(16)) - 8);
        xi = real'(int'($urandom_range(16)) - 8);
        yr = real'(int'($urandom_range(16)) - 8);
        yi = real'(int'($urandom_range(16)) - 8);
      end
      p.xr = $realtobits(xr); p.xi = $realtobits(xi);
      p.yr = $realtobits(yr); p.yi = $realtobits(yi);
      p.last = with_last && (i == n - 1);
      src_q.push_back(p);
      b[4*k+0] = p.xr; b[4*k+1] = p.xi; b[4*k+2] = p.yr; b[4*k+3] = p.yi;
      sr = sr + (xr * yr - xi * yi);
      si = si + (xr * yi + xi * yr);
      k++;
      if (p.last || k == SIZE) begin
        exp_beat_q.push_back(b);
        exp_res_q.push_back({p.last, $realtobits(si), $realtobits(sr)});
        b = '0; sr = 0.0; si = 0.0; k = 0;
      end
    end
  endtask

  // Operand source
  initial begin
    elem_valid_i = 1'b0; elem_x_i = '0; elem_y_i = '0; elem_last_i = 1'b0;
    forever begin
      @(negedge clk);
      if (src_en && src_q.size() > 0 && (!throttle || $urandom_range(3) != 0)) begin
        elem_valid_i = 1'b1;
        elem_x_i     = {src_q[0].xi, src_q[0].xr};
        elem_y_i     = {src_q[0].yi, src_q[0].yr};
        elem_last_i  = src_q[0].last;
      end else begin
        elem_valid_i = 1'b0;
      end
      #1;
      if (elem_valid_i && elem_ready_o && rst_ni && !flush_i) void'(src_q.pop_front());
    end
  end

  // Engine input side: checks beats, holds, and computes the sum the engine would return.
  initial begin
    beat_t prev_ops;
    bit prev_pend;
    beat_t b;
    real sr, si;
    prev_pend = 1'b0; prev_ops = '0;
    eng_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      eng_ready_i = eng_rdy_en && (!throttle || $urandom_range(1) == 1);
      #1;
      if (prev_pend && !flush_i && rst_ni) begin
        check_eq("eng_hold_valid", eng_valid_o, 1);
        check_eq("eng_hold_data", eng_operands_o == prev_ops, 1);
      end
      if (eng_valid_o) check_eq("elem_ready_in_issue", elem_ready_o, 0);
      prev_pend = eng_valid_o && !eng_ready_i;
      prev_ops  = eng_operands_o;
      if (eng_valid_o && eng_ready_i) begin
        issued++;
        if (exp_beat_q.size() == 0) begin
          check_eq("beat_unexpected", exp_beat_q.size(), 1);
        end else begin
          b = exp_beat_q.pop_front();
          for (int k = 0; k < SIZE; k++)
            check_eq($sformatf("lane%0d", k), eng_operands_o[4*k+3 -: 4], b[4*k+3 -: 4]);
        end
        sr = 0.0; si = 0.0;
        for (int k = 0; k < SIZE; k++) begin
          sr = sr + ($bitstoreal(eng_operands_o[4*k]) * $bitstoreal(eng_operands_o[4*k+2])
                   - $bitstoreal(eng_operands_o[4*k+1]) * $bitstoreal(eng_operands_o[4*k+3]));
          si = si + ($bitstoreal(eng_operands_o[4*k]) * $bitstoreal(eng_operands_o[4*k+3])
                   + $bitstoreal(eng_operands_o[4*k+1]) * $bitstoreal(eng_operands_o[4*k+2]));
        end
        eng_q.push_back({$realtobits(si), $realtobits(sr)});
      end
    end
  end

  // Engine result side
  initial begin
    eng_valid_i = 1'b0; eng_result_i = '0;
    forever begin
      @(negedge clk);
      if (resp_en && eng_q.size() > 0 && (!throttle || $urandom_range(1) == 1)) begin
        eng_valid_i  = 1'b1;
        eng_result_i = eng_q[0];
      end else begin
        eng_valid_i = 1'b0;
      end
      #1;
      if (eng_valid_i) check_eq("eng_ready", eng_ready_o, 1);
      if (eng_valid_i && eng_ready_o) void'(eng_q.pop_front());
    end
  end

  // Result sink
  initial begin
    logic [128:0] e;
    res_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      res_ready_i = sink_en && (!throttle || $urandom_range(1) == 1);
      #1;
      if (res_valid_o && res_ready_i) begin
        if (exp_res_q.size() == 0) begin
          check_eq("res_unexpected", exp_res_q.size(), 1);
        end else begin
          e = exp_res_q.pop_front();
          check_eq("res_data", res_data_o, e[127:0]);
          check_eq("res_last", res_last_o, e[128]);
        end
      end
    end
  end

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while ((src_q.size() != 0 || exp_beat_q.size() != 0 || exp_res_q.size() != 0)
           && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_drain_timeout"}, cyc < 3000, 1);
    repeat (3) @(negedge clk);
    #2;
    check_eq({tag, "_idle_busy"}, busy_o, 0);
  endtask

  initial begin
    int base;
    int cyc;
    beat_t ops0;
    rst_ni = 1'b0; flush_i = 1'b0;
    src_en = 0; eng_rdy_en = 0; resp_en = 0; sink_en = 0; throttle = 0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_elem_ready", elem_ready_o, 1);
    check_eq("rst_eng_valid", eng_valid_o, 0);
    check_eq("rst_res_valid", res_valid_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_eng_ready", eng_ready_o, 1);
    @(negedge clk);
    rst_ni = 1'b1;
    src_en = 1; eng_rdy_en = 1; resp_en = 1; sink_en = 1;

    // Four (1,0)x(2,0) pairs -> one beat, result 8.0
    base = issued;
    add_vector(4, 1, 1);
    drain("t1");
    check_eq("t1_beats", issued - base, 1);

    // Twenty pairs -> a full beat (tag 0) then a 4-lane beat (tag 1)
    base = issued;
    add_vector(20, 1, 0);
    drain("t2");
    check_eq("t2_beats", issued - base, 2);

    // Sink stalled: only RES_DEPTH beats may go out
    base = issued;
    sink_en = 0;
    for (int i = 0; i < 6; i++) add_vector(1, 1, 0);
    repeat (60) @(negedge clk);
    #2;
    check_eq("t3_beats_stalled", issued - base, RES_DEPTH);
    check_eq("t3_eng_valid_no_credit", eng_valid_o, 0);
    check_eq("t3_elem_ready", elem_ready_o, 0);
    check_eq("t3_busy", busy_o, 1);
    sink_en = 1;
    drain("t3");
    check_eq("t3_beats", issued - base, 6);

    // Engine stalls during ISSUE: operands must hold
    eng_rdy_en = 0;
    add_vector(3, 1, 0);
    cyc = 0;
    while (!eng_valid_o && cyc < 50) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check_eq("t4_valid_rise", eng_valid_o, 1);
    ops0 = eng_operands_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      check_eq("t4_ops_stable", eng_operands_o == ops0, 1);
      check_eq("t4_elem_ready", elem_ready_o, 0);
    end
    eng_rdy_en = 1;
    drain("t4");

    // Randomized traffic with throttling everywhere
    throttle = 1;
    for (int v = 0; v < 12; v++) add_vector(1 + int'($urandom_range(39)), 1, 0);
    drain("rand");
    throttle = 0;

    // Flush with 7 lanes filled and 2 credits held
    sink_en = 0;
    add_vector(1, 1, 0);
    add_vector(1, 1, 0);
    repeat (20) @(negedge clk);
    add_vector(7, 0, 0);
    repeat (20) @(negedge clk);
    #2;
    check_eq("t6_busy_before", busy_o, 1);
    check_eq("t6_res_valid_before", res_valid_o, 1);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check_eq("t6_eng_flush", eng_flush_o, 1);
    @(negedge clk);
    flush_i = 1'b0;
    #2;
    check_eq("t6_busy_after", busy_o, 0);
    check_eq("t6_res_valid_after", res_valid_o, 0);
    src_q.delete(); exp_beat_q.delete(); exp_res_q.delete(); eng_q.delete();
    sink_en = 1;
    add_vector(1, 1, 0);
    drain("t6");

    // Stray engine result: sticky error, nothing delivered
    eng_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (5) @(negedge clk);
    #2;
    check_eq("t5_err", err_o, 1);
    check_eq("t5_res_valid", res_valid_o, 0);
    add_vector(2, 1, 0);
    drain("t5");
    check_eq("t5_err_sticky", err_o, 1);
    rst_ni = 1'b0;
    #2;
    check_eq("t5_err_reset", err_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
